mem_stage: RTL and testbench
============================

# mem_stage

Data-memory stage of the MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It performs word loads and stores against an internal data memory with a configurable access latency. It asserts `stall` to freeze the upstream pipeline while an access is in progress, and injects a bubble into MEM/WB until the access completes.

## Interface
Parameters:
- `DEPTH`, 256: data memory size in 32-bit words; power of two.
- `LAT`, 3: cycles per load/store access; must be ≥1.

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `Address`  in  32  byte address from EX/MEM (ALU result)
- `Write_Data`  in  32  store data from EX/MEM
- `regdst_i`  in  5  destination register from EX/MEM
- `MemRead`  in  1  load request
- `MemWrite`  in  1  store request
- `RegWrite_i`  in  1  register-write control from EX/MEM
- `MemtoReg_i`  in  1  writeback-select control from EX/MEM
- `Read_Data`  out  32  load data to MEM/WB
- `Address_o`  out  32  `Address` passed through to MEM/WB
- `regdst`  out  5  `regdst_i` passed through
- `RegWrite`  out  1  gated register-write control to MEM/WB
- `MemtoReg`  out  1  `MemtoReg_i` passed through
- `stall`  out  1  freeze request to PC, IF/ID, ID/EX and EX/MEM
- `misaligned`  out  1  `Address[1:0] != 0` while a memory op is present

## Operation
- `mem_op = MemRead | MemWrite`.
- Word index is `Address[log2(DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- Memory array: 32-bit × DEPTH with combinational read. It is not cleared by reset.
- Access counter `cnt`, width `clog2(LAT)` (min 1), reset 0.
  - FSM view: IDLE (`cnt==0`, no op) → BUSY (`0<cnt<LAT-1` or first cycle of an op) → FINAL (`cnt==LAT-1`).
- `stall = mem_op & (cnt != LAT-1) & ~rst`.
  - With LAT=1, `stall` is never asserted.
- Counter update at posedge:
  - If `mem_op` and `cnt==LAT-1`: `cnt<=0`; the access completes.
  - Else if `mem_op`: `cnt<=cnt+1`.
  - Else: `cnt<=0`.
- Store commit: memory written with `Write_Data` only on the completing edge (`MemWrite & cnt==LAT-1 & ~misaligned & ~rst`).
  - Exactly one write per access.
  - A misaligned store is dropped.
- `Read_Data` = memory word at the index, valid in the FINAL cycle.
  - If `MemRead` and `MemWrite` are both asserted, the access is treated as a store; `Read_Data` shows the pre-write contents.
  - A misaligned load still returns the aligned word.
- `RegWrite = RegWrite_i & ~stall & ~rst`. MEM/WB therefore captures a bubble on every stalled cycle.
- `Address_o`, `regdst` and `MemtoReg` are pure pass-throughs.
- Upstream must hold all inputs stable while `stall` is high. Behaviour on input change mid-access is undefined.

## Timing
- Reset values while `rst`=1: `cnt`=0, `stall`=0, `RegWrite`=0.
  - `Read_Data`, `Address_o`, `regdst`, `MemtoReg` and `misaligned` follow their inputs combinationally.
- Reset mid-access: `cnt` clears immediately and any pending store is lost. After deassertion, an op still present restarts at cycle 0 (full LAT cycles).
- Access latency:
  - An op presented in cycle t has `stall`=1 in cycles t..t+LAT-2.
  - `stall`=0 and data valid in cycle t+LAT-1.
  - MEM/WB captures the result at the end of cycle t+LAT-1.
- Back-to-back ops: the next op arrives in cycle t+LAT. It starts from `cnt`=0 and also takes LAT cycles. There are no idle cycles in between.
- Non-memory instructions pass with zero added latency. `stall` stays 0 and `RegWrite` equals `RegWrite_i`.
- Store then load to the same word in consecutive accesses: the load returns the newly stored data, because the write commits on the edge before the load's first cycle.

## Test plan
- Reset during idle, then `RegWrite_i`=1 with no mem op, `regdst_i`=5'd9 → `stall`=0 every cycle, `RegWrite`=1, `regdst`=9, `cnt` stays 0.
- LAT=3: store `Address`=0x10, `Write_Data`=0xDEADBEEF → `stall`=1,1,0 over three cycles; the word at index 4 updates only on the third edge. A following load from 0x10 → `Read_Data`=0xDEADBEEF in its third cycle with `RegWrite`=1; `RegWrite`=0 in its first two cycles.
- Wrap-around, DEPTH=256: store 0x11111111 to `Address`=0x400, then load from 0x0 → `Read_Data`=0x11111111.
- Misaligned store to 0x22 with data 0xCAFEF00D → `misaligned`=1, word at index 8 unchanged afterwards, `stall` still follows the LAT=3 pattern.
- Reset pulse in cycle 2 of a 3-cycle store of 0x12345678 to 0x20 → `cnt`=0 and `stall`=0 during reset, memory unchanged. After release with inputs held, the store takes a full 3 cycles and then commits.
- LAT=1 build: alternating load/store/ALU ops each cycle → `stall` never asserted; each store is visible to a load on the next cycle.

Source files
------------

// File: rtl/mem_stage.sv
// Data-memory stage of the MIPS pipeline: word loads/stores against an internal
// array with LAT-cycle access, stalling upstream and bubbling MEM/WB until done.
module mem_stage #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned LAT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] Write_Data,
    input  logic [4:0]  regdst_i,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    output logic [31:0] Read_Data,
    output logic [31:0] Address_o,
    output logic [4:0]  regdst,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        stall,
    output logic        misaligned
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

    logic [31:0]   r_mem [DEPTH];
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [AW-1:0] w_idx;
    logic          w_mem_op;
    logic          w_final;
    logic          w_commit;

    assign w_mem_op = MemRead | MemWrite;
    assign w_idx    = Address[AW+1:2];
    assign w_final  = (r_cnt == CNT_LAST);

    // Access counter; async clear drops any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    always_comb begin
        w_cnt_next = '0;
        if (w_mem_op && !w_final) begin
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    always_comb begin
        misaligned = w_mem_op & (Address[1:0] != 2'b00);
        stall      = w_mem_op & ~w_final & ~rst;
        RegWrite   = RegWrite_i & ~stall & ~rst;
        w_commit   = MemWrite & w_final & ~misaligned & ~rst;
    end

    // Store lands only on the completing edge; array is never reset
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= Write_Data;
        end
    end

    assign Read_Data = r_mem[w_idx];
    assign Address_o = Address;
    assign regdst    = regdst_i;
    assign MemtoReg  = MemtoReg_i;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a LAT=3 instance and a LAT=1 instance, both DEPTH=256.
module tb_mem_stage;

    logic        clk;
    logic        rst;

    logic [31:0] a_addr, a_wdata;
    logic [4:0]  a_rd;
    logic        a_mr, a_mw, a_rw, a_m2r;
    logic [31:0] a_rdata, a_addr_o;
    logic [4:0]  a_regdst;
    logic        a_regwrite, a_memtoreg, a_stall, a_mis;

    logic [31:0] b_addr, b_wdata;
    logic [4:0]  b_rd;
    logic        b_mr, b_mw, b_rw, b_m2r;
    logic [31:0] b_rdata, b_addr_o;
    logic [4:0]  b_regdst;
    logic        b_regwrite, b_memtoreg, b_stall, b_mis;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage #(.DEPTH(256), .LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .Address(a_addr), .Write_Data(a_wdata), .regdst_i(a_rd),
        .MemRead(a_mr), .MemWrite(a_mw), .RegWrite_i(a_rw), .MemtoReg_i(a_m2r),
        .Read_Data(a_rdata), .Address_o(a_addr_o), .regdst(a_regdst),
        .RegWrite(a_regwrite), .MemtoReg(a_memtoreg), .stall(a_stall),
        .misaligned(a_mis)
    );

    mem_stage #(.DEPTH(256), .LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .Address(b_addr), .Write_Data(b_wdata), .regdst_i(b_rd),
        .MemRead(b_mr), .MemWrite(b_mw), .RegWrite_i(b_rw), .MemtoReg_i(b_m2r),
        .Read_Data(b_rdata), .Address_o(b_addr_o), .regdst(b_regdst),
        .RegWrite(b_regwrite), .MemtoReg(b_memtoreg), .stall(b_stall),
        .misaligned(b_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [31:0] addr, input logic [31:0] wd,
                         input logic mr, input logic mw, input logic rw, input logic m2r);
        a_addr = addr; a_wdata = wd; a_mr = mr; a_mw = mw; a_rw = rw; a_m2r = m2r;
    endtask

    task automatic set_b(input logic [31:0] addr, input logic [31:0] wd,
                         input logic mr, input logic mw, input logic rw);
        b_addr = addr; b_wdata = wd; b_mr = mr; b_mw = mw; b_rw = rw; b_m2r = mr; b_rd = 5'd3;
    endtask

    initial begin
        rst = 1'b1;
        a_rd = 5'd0;
        set_a(32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        set_b(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_stall", 32'(a_stall), 32'h0);
        chk("rst_regwrite", 32'(a_regwrite), 32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Non-memory op: zero added latency
        a_rd = 5'd9;
        set_a(32'h0000_0003, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("alu_stall", 32'(a_stall), 32'h0);
            chk("alu_regwrite", 32'(a_regwrite), 32'h1);
            next_cycle();
        end
        chk("alu_regdst", 32'(a_regdst), 32'd9);
        chk("alu_misaligned", 32'(a_mis), 32'h0);
        chk("alu_addr_o", a_addr_o, 32'h0000_0003);

        // Store 0xDEADBEEF to 0x10: stall 1,1,0
        set_a(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        #1; chk("st1_stall_c0", 32'(a_stall), 32'h1);
        next_cycle(); #1; chk("st1_stall_c1", 32'(a_stall), 32'h1);
        next_cycle(); #1; chk("st1_stall_c2", 32'(a_stall), 32'h0);
        chk("st1_misaligned", 32'(a_mis), 32'h0);

        // Load back from 0x10
        next_cycle();
        set_a(32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1; chk("ld1_stall_c0", 32'(a_stall), 32'h1);
        chk("ld1_rw_c0", 32'(a_regwrite), 32'h0);
        chk("ld1_memtoreg", 32'(a_memtoreg), 32'h1);
        next_cycle(); #1; chk("ld1_rw_c1", 32'(a_regwrite), 32'h0);
        next_cycle(); #1; chk("ld1_stall_c2", 32'(a_stall), 32'h0);
        chk("ld1_rw_c2", 32'(a_regwrite), 32'h1);
        chk("ld1_data", a_rdata, 32'hDEAD_BEEF);

        // Wrap-around: 0x400 aliases word 0
        next_cycle();
        set_a(32'h400, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle(); next_cycle(); next_cycle();
        set_a(32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        next_cycle(); next_cycle(); #1;
        chk("wrap_data", a_rdata, 32'h1111_1111);

        // Seed word 8 with a known value
        next_cycle();
        set_a(32'h20, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle(); next_cycle(); next_cycle();

        // Misaligned store to 0x22 is dropped but still takes LAT cycles
        set_a(32'h22, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b0);
        #1; chk("mis_flag", 32'(a_mis), 32'h1);
        chk("mis_stall_c0", 32'(a_stall), 32'h1);
        next_cycle(); #1; chk("mis_stall_c1", 32'(a_stall), 32'h1);
        next_cycle(); #1; chk("mis_stall_c2", 32'(a_stall), 32'h0);
        next_cycle();
        set_a(32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        next_cycle(); next_cycle(); #1;
        chk("mis_word8_kept", a_rdata, 32'h5555_5555);

        // Reset pulse in cycle 2 of a store of 0x12345678 to 0x20
        next_cycle();
        set_a(32'h20, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0);
        #1; chk("rs_stall_c0", 32'(a_stall), 32'h1);
        next_cycle();
        rst = 1'b1;
        #1; chk("rs_stall_in_rst", 32'(a_stall), 32'h0);
        chk("rs_mem_in_rst", a_rdata, 32'h5555_5555);
        next_cycle();
        rst = 1'b0;
        #1; chk("rs_restart_c0", 32'(a_stall), 32'h1);
        chk("rs_mem_after", a_rdata, 32'h5555_5555);
        next_cycle(); #1; chk("rs_restart_c1", 32'(a_stall), 32'h1);
        next_cycle(); #1; chk("rs_restart_c2", 32'(a_stall), 32'h0);
        chk("rs_prewrite", a_rdata, 32'h5555_5555);
        next_cycle();
        set_a(32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1; chk("rs_committed", a_rdata, 32'h1234_5678);
        next_cycle(); next_cycle();
        set_a(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // LAT=1: alternating store/load/ALU, never stalls
        set_b(32'h40, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0);
        #1; chk("l1_st1_stall", 32'(b_stall), 32'h0);
        next_cycle();
        set_b(32'h40, 32'h0, 1'b1, 1'b0, 1'b1);
        #1; chk("l1_ld1_stall", 32'(b_stall), 32'h0);
        chk("l1_ld1_data", b_rdata, 32'hA5A5_0001);
        chk("l1_ld1_rw", 32'(b_regwrite), 32'h1);
        next_cycle();
        set_b(32'h44, 32'h0, 1'b0, 1'b0, 1'b1);
        #1; chk("l1_alu_stall", 32'(b_stall), 32'h0);
        chk("l1_alu_rw", 32'(b_regwrite), 32'h1);
        next_cycle();
        set_b(32'h40, 32'h0BAD_CAFE, 1'b0, 1'b1, 1'b0);
        #1; chk("l1_st2_stall", 32'(b_stall), 32'h0);
        chk("l1_st2_prewrite", b_rdata, 32'hA5A5_0001);
        next_cycle();
        set_b(32'h40, 32'h0, 1'b1, 1'b0, 1'b1);
        #1; chk("l1_ld2_data", b_rdata, 32'h0BAD_CAFE);
        chk("l1_ld2_stall", 32'(b_stall), 32'h0);
        next_cycle();
        set_b(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
